// File: rtl/lca_pkg.sv
// lca_pkg: shared constants and types for the LM/SM micro-op sequencer.
//   OP_LM / OP_SM : opcodes found in ir[15:12]
//   NOP_IR        : instruction presented on new_ir while nothing is expanded
//   seq_state_e   : sequencer FSM state encoding
//   build_uop     : packs one single-register micro-op
package lca_pkg;

  localparam logic [3:0]  OP_LM  = 4'b0110;
  localparam logic [3:0]  OP_SM  = 4'b0111;
  localparam logic [15:0] NOP_IR = 16'hF000;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_EXPAND = 1'b1
  } seq_state_e;

  // Micro-op layout: {op, base reg, transfer reg, 4'b0000, last, first}.
  function automatic logic [15:0] build_uop(
    input logic [3:0] op,
    input logic [2:0] ra,
    input logic [2:0] idx,
    input logic       last,
    input logic       first
  );
    return {op, ra, idx, 4'b0000, last, first};
  endfunction

endpackage

// File: rtl/lowest_set_bit8.sv
// lowest_set_bit8: combinational priority encoder, lowest index wins.
// Ports:
//   mask  in  8  bit vector to scan
//   idx   out 3  index of the lowest set bit (0 when mask is zero)
//   zero  out 1  mask has no bit set
module lowest_set_bit8 (
  input  logic [7:0] mask,
  output logic [2:0] idx,
  output logic       zero
);

  // Priority scan from bit 0 upward.
  always_comb begin
    idx  = 3'd0;
    zero = (mask == 8'h00);
    casez (mask)
      8'b???????1: idx = 3'd0;
      8'b??????10: idx = 3'd1;
      8'b?????100: idx = 3'd2;
      8'b????1000: idx = 3'd3;
      8'b???10000: idx = 3'd4;
      8'b??100000: idx = 3'd5;
      8'b?1000000: idx = 3'd6;
      8'b10000000: idx = 3'd7;
      default:     idx = 3'd0;
    endcase
  end

endmodule

// File: rtl/lm_sm_sequencer.sv
// lm_sm_sequencer: expands an LM/SM instruction sitting in IF/ID into one
// single-register micro-op per set mask bit (lowest register first) while
// freezing the PC.
// Ports:
//   clk, reset      clock and synchronous active-high reset
//   ir_in, ir_valid instruction in IF/ID and its valid flag
//   stall, flush    hazard hold and taken-branch abort
//   new_ir          micro-op to load into IF/ID when ir_load_mux=1
//   ir_load_mux     select new_ir over the fetched instruction
//   first_multiple  current micro-op is the first of its sequence
//   pc_write        PC update enable
//   busy            sequencer is expanding
module lm_sm_sequencer
  import lca_pkg::*;
#(
  parameter int MASK_W = 8,
  parameter int IR_W   = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [IR_W-1:0] ir_in,
  input  logic            ir_valid,
  input  logic            stall,
  input  logic            flush,
  output logic [IR_W-1:0] new_ir,
  output logic            ir_load_mux,
  output logic            first_multiple,
  output logic            pc_write,
  output logic            busy
);

  seq_state_e        state_r;
  seq_state_e        state_nxt_s;
  logic [MASK_W-1:0] mask_r;
  logic [3:0]        op_r;
  logic [2:0]        ra_r;
  logic              first_r;

  logic [3:0]        opcode_s;
  logic              is_multi_s;
  logic              start_s;
  logic              busy_s;
  logic [2:0]        idx_s;
  logic              mask_zero_s;
  logic [MASK_W-1:0] mask_next_s;
  logic              last_s;
  logic              unused_ir_bit_s;

  assign opcode_s   = ir_in[15:12];
  assign is_multi_s = (opcode_s == OP_LM) || (opcode_s == OP_SM);
  assign start_s    = (state_r == ST_IDLE) && ir_valid && is_multi_s &&
                      (ir_in[MASK_W-1:0] != {MASK_W{1'b0}}) && !stall && !flush;
  assign busy_s     = (state_r == ST_EXPAND);

  // Bit 8 of an LM/SM has no meaning to the sequencer.
  assign unused_ir_bit_s = ir_in[8];

  lowest_set_bit8 u_lsb (
    .mask (mask_r),
    .idx  (idx_s),
    .zero (mask_zero_s)
  );

  // x & (x-1) clears exactly the lowest set bit, i.e. bit idx_s.
  assign mask_next_s = mask_r & (mask_r - {{(MASK_W-1){1'b0}}, 1'b1});
  assign last_s      = (mask_next_s == {MASK_W{1'b0}});

  // FSM next-state selection; flush wins over stall and advance.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_s) begin
          state_nxt_s = ST_EXPAND;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_EXPAND: begin
        if (flush) begin
          state_nxt_s = ST_IDLE;
        end else if (mask_zero_s) begin
          // Empty mask while expanding cannot occur normally; recover to IDLE.
          state_nxt_s = ST_IDLE;
        end else if (stall) begin
          state_nxt_s = ST_EXPAND;
        end else if (last_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_EXPAND;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State, mask and captured instruction fields.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      mask_r  <= {MASK_W{1'b0}};
      op_r    <= 4'd0;
      ra_r    <= 3'd0;
      first_r <= 1'b0;
    end else if (flush) begin
      state_r <= ST_IDLE;
      mask_r  <= {MASK_W{1'b0}};
      first_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if (start_s) begin
        op_r    <= opcode_s;
        ra_r    <= ir_in[11:9];
        mask_r  <= ir_in[MASK_W-1:0];
        first_r <= 1'b1;
      end else if (busy_s && !stall) begin
        mask_r  <= mask_next_s;
        first_r <= 1'b0;
      end else begin
        mask_r  <= mask_r;
        first_r <= first_r;
      end
    end
  end

  // Output decode from current state and inputs.
  always_comb begin
    new_ir         = NOP_IR;
    ir_load_mux    = busy_s;
    busy           = busy_s;
    first_multiple = busy_s & first_r;
    pc_write       = !(start_s | (busy_s & !last_s)) & !stall;
    if (busy_s && !mask_zero_s) begin
      new_ir = build_uop(op_r, ra_r, idx_s, last_s, first_r);
    end else begin
      new_ir = NOP_IR;
    end
  end

endmodule

// File: tb/tb_lm_sm_sequencer.sv
module tb_lm_sm_sequencer;

  logic        clk;
  logic        reset;
  logic [15:0] ir_in;
  logic        ir_valid;
  logic        stall;
  logic        flush;
  logic [15:0] new_ir;
  logic        ir_load_mux;
  logic        first_multiple;
  logic        pc_write;
  logic        busy;

  int checks;
  int errors;

  lm_sm_sequencer #(.MASK_W(8), .IR_W(16)) dut (
    .clk            (clk),
    .reset          (reset),
    .ir_in          (ir_in),
    .ir_valid       (ir_valid),
    .stall          (stall),
    .flush          (flush),
    .new_ir         (new_ir),
    .ir_load_mux    (ir_load_mux),
    .first_multiple (first_multiple),
    .pc_write       (pc_write),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; ir_in = 16'h0000; ir_valid = 1'b0; stall = 1'b0; flush = 1'b0;
    tick(); tick();
    reset = 1'b0;
    @(negedge clk);
    checks++; if (new_ir !== 16'hF000) begin errors++; $display("FAIL reset_new_ir: got %h expected f000", new_ir); end
    checks++; if (ir_load_mux !== 1'b0) begin errors++; $display("FAIL reset_ir_load_mux: got %b expected 0", ir_load_mux); end
    checks++; if (first_multiple !== 1'b0) begin errors++; $display("FAIL reset_first: got %b expected 0", first_multiple); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (pc_write !== 1'b1) begin errors++; $display("FAIL reset_pc_write: got %b expected 1", pc_write); end
    tick();
  endtask

  task automatic test_lm3;
    logic [15:0] exp_ir [0:2];
    exp_ir[0] = 16'h6201; exp_ir[1] = 16'h6280; exp_ir[2] = 16'h63C2;
    ir_in = 16'h6285; ir_valid = 1'b1;
    @(negedge clk);
    checks++; if (pc_write !== 1'b0) begin errors++; $display("FAIL lm3_start_pc_write: got %b expected 0", pc_write); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL lm3_start_busy: got %b expected 0", busy); end
    tick();
    ir_valid = 1'b0; ir_in = 16'h0000;
    for (int j = 1; j <= 3; j++) begin
      @(negedge clk);
      checks++; if (new_ir !== exp_ir[j-1]) begin errors++; $display("FAIL lm3_uop%0d: got %h expected %h", j, new_ir, exp_ir[j-1]); end
      checks++; if (first_multiple !== (j == 1)) begin errors++; $display("FAIL lm3_first%0d: got %b expected %b", j, first_multiple, (j == 1)); end
      checks++; if (pc_write !== (j == 3)) begin errors++; $display("FAIL lm3_pc_write%0d: got %b expected %b", j, pc_write, (j == 3)); end
      checks++; if (ir_load_mux !== 1'b1) begin errors++; $display("FAIL lm3_mux%0d: got %b expected 1", j, ir_load_mux); end
      tick();
    end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL lm3_done_busy: got %b expected 0", busy); end
    checks++; if (new_ir !== 16'hF000) begin errors++; $display("FAIL lm3_done_new_ir: got %h expected f000", new_ir); end
    tick();
  endtask

  task automatic test_sm_full;
    int busy_cnt;
    logic [15:0] exp;
    busy_cnt = 0;
    ir_in = 16'h76FF; ir_valid = 1'b1;
    tick();
    ir_valid = 1'b0; ir_in = 16'h0000;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (busy === 1'b1) busy_cnt++;
      if (c < 8) begin
        // SM, RA=R3, transfer reg c, last on c==7, first on c==0
        exp = 16'h7600 | (16'(c) << 6) | ((c == 7) ? 16'h0002 : 16'h0000) | ((c == 0) ? 16'h0001 : 16'h0000);
        checks++; if (new_ir !== exp) begin errors++; $display("FAIL sm_full_uop%0d: got %h expected %h", c, new_ir, exp); end
      end
      tick();
    end
    checks++; if (busy_cnt != 8) begin errors++; $display("FAIL sm_full_busy_cycles: got %0d expected 8", busy_cnt); end
  endtask

  task automatic test_stall;
    logic [15:0] exp_ir [0:4];
    logic        exp_pc [0:4];
    logic        stall_v [0:4];
    exp_ir[0] = 16'h6401; exp_pc[0] = 1'b0; stall_v[0] = 1'b0;
    exp_ir[1] = 16'h6440; exp_pc[1] = 1'b0; stall_v[1] = 1'b1;
    exp_ir[2] = 16'h6440; exp_pc[2] = 1'b0; stall_v[2] = 1'b0;
    exp_ir[3] = 16'h6480; exp_pc[3] = 1'b0; stall_v[3] = 1'b0;
    exp_ir[4] = 16'h64C2; exp_pc[4] = 1'b1; stall_v[4] = 1'b0;
    ir_in = 16'h640F; ir_valid = 1'b1;
    @(negedge clk);
    checks++; if (pc_write !== 1'b0) begin errors++; $display("FAIL stall_start_pc_write: got %b expected 0", pc_write); end
    tick();
    ir_valid = 1'b0; ir_in = 16'h0000;
    for (int j = 0; j < 5; j++) begin
      stall = stall_v[j];
      @(negedge clk);
      checks++; if (new_ir !== exp_ir[j]) begin errors++; $display("FAIL stall_uop_c%0d: got %h expected %h", j + 1, new_ir, exp_ir[j]); end
      checks++; if (pc_write !== exp_pc[j]) begin errors++; $display("FAIL stall_pc_write_c%0d: got %b expected %b", j + 1, pc_write, exp_pc[j]); end
      tick();
    end
    stall = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stall_done_busy: got %b expected 0", busy); end
    tick();
  endtask

  task automatic test_flush;
    ir_in = 16'h60F0; ir_valid = 1'b1;
    tick();
    ir_valid = 1'b0; ir_in = 16'h0000;
    @(negedge clk);
    checks++; if (new_ir !== 16'h6101) begin errors++; $display("FAIL flush_uop1: got %h expected 6101", new_ir); end
    tick();
    flush = 1'b1;
    @(negedge clk);
    checks++; if (new_ir !== 16'h6140) begin errors++; $display("FAIL flush_uop2: got %h expected 6140", new_ir); end
    tick();
    flush = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if (ir_load_mux !== 1'b0) begin errors++; $display("FAIL flush_mux_c%0d: got %b expected 0", c, ir_load_mux); end
      checks++; if (pc_write !== 1'b1) begin errors++; $display("FAIL flush_pc_write_c%0d: got %b expected 1", c, pc_write); end
      checks++; if (new_ir !== 16'hF000) begin errors++; $display("FAIL flush_new_ir_c%0d: got %h expected f000", c, new_ir); end
      tick();
    end
  endtask

  task automatic test_zero_mask;
    ir_in = 16'h6200; ir_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL zero_busy_c%0d: got %b expected 0", c, busy); end
      checks++; if (ir_load_mux !== 1'b0) begin errors++; $display("FAIL zero_mux_c%0d: got %b expected 0", c, ir_load_mux); end
      checks++; if (pc_write !== 1'b1) begin errors++; $display("FAIL zero_pc_write_c%0d: got %b expected 1", c, pc_write); end
      tick();
    end
    ir_valid = 1'b0; ir_in = 16'h0000;
  endtask

  task automatic test_back_to_back;
    // LM R1 mask 0x03, then SM R1 mask 0x01 held on ir_in during the expansion.
    ir_in = 16'h6203; ir_valid = 1'b1;
    tick();
    ir_in = 16'h7201;
    @(negedge clk);
    checks++; if (new_ir !== 16'h6201) begin errors++; $display("FAIL b2b_uop1: got %h expected 6201", new_ir); end
    tick();
    @(negedge clk);
    checks++; if (new_ir !== 16'h6242) begin errors++; $display("FAIL b2b_uop2: got %h expected 6242", new_ir); end
    checks++; if (pc_write !== 1'b1) begin errors++; $display("FAIL b2b_last_pc_write: got %b expected 1", pc_write); end
    tick();
    @(negedge clk);
    checks++; if (pc_write !== 1'b0) begin errors++; $display("FAIL b2b_restart_pc_write: got %b expected 0", pc_write); end
    tick();
    ir_valid = 1'b0; ir_in = 16'h0000;
    @(negedge clk);
    checks++; if (new_ir !== 16'h7203) begin errors++; $display("FAIL b2b_sm_uop: got %h expected 7203", new_ir); end
    checks++; if (first_multiple !== 1'b1) begin errors++; $display("FAIL b2b_sm_first: got %b expected 1", first_multiple); end
    tick();
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_done_busy: got %b expected 0", busy); end
    tick();
  endtask

  task automatic test_reset_mid;
    ir_in = 16'h7A1F; ir_valid = 1'b1;
    tick();
    ir_valid = 1'b0; ir_in = 16'h0000;
    @(negedge clk);
    checks++; if (new_ir !== 16'h7A01) begin errors++; $display("FAIL rmid_uop1: got %h expected 7a01", new_ir); end
    tick();
    reset = 1'b1;
    @(negedge clk);
    checks++; if (new_ir !== 16'h7A40) begin errors++; $display("FAIL rmid_uop2: got %h expected 7a40", new_ir); end
    tick();
    reset = 1'b0;
    @(negedge clk);
    checks++; if (new_ir !== 16'hF000) begin errors++; $display("FAIL rmid_new_ir: got %h expected f000", new_ir); end
    checks++; if (ir_load_mux !== 1'b0) begin errors++; $display("FAIL rmid_mux: got %b expected 0", ir_load_mux); end
    checks++; if (first_multiple !== 1'b0) begin errors++; $display("FAIL rmid_first: got %b expected 0", first_multiple); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b expected 0", busy); end
    checks++; if (pc_write !== 1'b1) begin errors++; $display("FAIL rmid_pc_write: got %b expected 1", pc_write); end
    tick();
    ir_in = 16'h6285; ir_valid = 1'b1;
    tick();
    ir_valid = 1'b0; ir_in = 16'h0000;
    @(negedge clk);
    checks++; if (new_ir !== 16'h6201) begin errors++; $display("FAIL rmid_after_uop1: got %h expected 6201", new_ir); end
    tick();
    @(negedge clk);
    checks++; if (new_ir !== 16'h6280) begin errors++; $display("FAIL rmid_after_uop2: got %h expected 6280", new_ir); end
    tick();
    @(negedge clk);
    checks++; if (new_ir !== 16'h63C2) begin errors++; $display("FAIL rmid_after_uop3: got %h expected 63c2", new_ir); end
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_lm3();
    test_sm_full();
    test_stall();
    test_flush();
    test_zero_mask();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
